// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC comb cascade.
// Build macro CIC_COMB_OVF_CNT_EN enables the integrator truncation-event counter.
package cic_pkg;

    localparam int DW_DEFAULT = 23;
    localparam int STAGES_MAX = 6;
    localparam int OVF_CNT_W  = 8;

    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 8'hFF;

    // Saturating increment used by the truncation-event counter.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        logic [OVF_CNT_W-1:0] r;
        if (v == OVF_CNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_comb_section.sv
// One registered comb section: y = x - x[n-M] modulo 2^DW, delay line shifted on x_valid.
module cic_comb_section
    import cic_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int DIFF_DELAY = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          x_valid,
    input  logic [DW-1:0] x,
    output logic          y_valid,
    output logic [DW-1:0] y
);

    logic [DW-1:0] dly_r [DIFF_DELAY];
    logic [DW-1:0] y_r;
    logic          y_valid_r;
    logic [DW-1:0] diff_s;

    // Wrapping difference against the oldest delay-line entry.
    always_comb begin
        diff_s = x - dly_r[DIFF_DELAY-1];
    end

    // Delay line, result register and valid passthrough.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dly_r[i] <= '0;
            end
            y_r       <= '0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= x_valid;
            if (x_valid) begin
                y_r      <= diff_s;
                dly_r[0] <= x;
                for (int i = 1; i < DIFF_DELAY; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;

endmodule

// File: rtl/cic_comb.sv
// CIC decimator comb cascade with output holding register, overrun flag and
// optional truncation-event counter (build macro CIC_COMB_OVF_CNT_EN).
module cic_comb
    import cic_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int STAGES     = 3,
    parameter int DIFF_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [DW-1:0]        data_in,
    input  logic [1:0]           flag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 overrun,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    output logic                 ovf_sign,
    input  logic                 ovf_clr
);

    logic [DW-1:0] sec_data_s [STAGES+1];
    logic [STAGES:0] sec_valid_s;

    assign sec_data_s[0]  = data_in;
    assign sec_valid_s[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_sec
        cic_comb_section #(
            .DW         (DW),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_sec (
            .clk     (clk),
            .reset_n (reset_n),
            .x_valid (sec_valid_s[k]),
            .x       (sec_data_s[k]),
            .y_valid (sec_valid_s[k+1]),
            .y       (sec_data_s[k+1])
        );
    end

    logic          load_s;
    logic [DW-1:0] result_s;
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          overrun_r;
    logic          out_valid_nxt_s;
    logic [DW-1:0] out_data_nxt_s;
    logic          overrun_nxt_s;

    assign load_s   = sec_valid_s[STAGES];
    assign result_s = sec_data_s[STAGES];

    // Output holding register: a new result always loads; acceptance only drains when idle.
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        overrun_nxt_s   = overrun_r;
        if (load_s) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = result_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
        // Setting wins over clearing so a coincident overrun is never lost.
        if (load_s && out_valid_r && !out_ready) begin
            overrun_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            overrun_r   <= 1'b0;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            overrun_r   <= overrun_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign overrun   = overrun_r;

`ifdef CIC_COMB_OVF_CNT_EN
    logic                 flag_q_r;
    logic [OVF_CNT_W-1:0] ovf_cnt_r;
    logic                 ovf_sign_r;
    logic                 event_s;
    logic [OVF_CNT_W-1:0] ovf_cnt_nxt_s;
    logic                 ovf_sign_nxt_s;
    logic                 flag_q_nxt_s;

    // A truncation event is a toggle of flag_in[0] seen on a sample strobe.
    always_comb begin
        event_s        = in_valid && (flag_in[0] != flag_q_r);
        flag_q_nxt_s   = flag_q_r;
        ovf_cnt_nxt_s  = ovf_cnt_r;
        ovf_sign_nxt_s = ovf_sign_r;
        if (in_valid) begin
            flag_q_nxt_s = flag_in[0];
        end else begin
            flag_q_nxt_s = flag_q_r;
        end
        if (ovf_clr) begin
            ovf_cnt_nxt_s  = event_s ? 8'd1 : 8'd0;
            ovf_sign_nxt_s = event_s ? flag_in[1] : 1'b0;
        end else if (event_s) begin
            ovf_cnt_nxt_s  = sat_inc(ovf_cnt_r);
            ovf_sign_nxt_s = flag_in[1];
        end else begin
            ovf_cnt_nxt_s  = ovf_cnt_r;
            ovf_sign_nxt_s = ovf_sign_r;
        end
    end

    // Event counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag_q_r   <= 1'b0;
            ovf_cnt_r  <= '0;
            ovf_sign_r <= 1'b0;
        end else begin
            flag_q_r   <= flag_q_nxt_s;
            ovf_cnt_r  <= ovf_cnt_nxt_s;
            ovf_sign_r <= ovf_sign_nxt_s;
        end
    end

    assign ovf_cnt  = ovf_cnt_r;
    assign ovf_sign = ovf_sign_r;
`else
    logic [1:0] unused_flag_s;

    assign unused_flag_s = flag_in;
    assign ovf_cnt       = '0;
    assign ovf_sign      = 1'b0;
`endif

endmodule

// File: tb/tb_cic_comb.sv
// Directed self-checking bench for cic_comb (DW=23, STAGES=3, M=1).
module tb_cic_comb;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [22:0] data_in;
    logic [1:0]  flag_in;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_data;
    logic        overrun;
    logic [7:0]  ovf_cnt;
    logic        ovf_sign;
    logic        ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [22:0] din_a [5];
    logic [22:0] exp_a [5];
    logic [22:0] s1_exp;

`ifdef CIC_COMB_OVF_CNT_EN
    localparam logic [7:0] EXP_CNT_SAT = 8'd255;
    localparam logic [7:0] EXP_CNT_ONE = 8'd1;
    localparam logic       EXP_SIGN    = 1'b1;
`else
    localparam logic [7:0] EXP_CNT_SAT = 8'd0;
    localparam logic [7:0] EXP_CNT_ONE = 8'd0;
    localparam logic       EXP_SIGN    = 1'b0;
`endif

    cic_comb #(
        .DW         (23),
        .STAGES     (3),
        .DIFF_DELAY (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .flag_in   (flag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overrun   (overrun),
        .ovf_cnt   (ovf_cnt),
        .ovf_sign  (ovf_sign),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        data_in  = 23'd0;
        tick();
        reset_n = 1'b1;
    endtask

    // Five back-to-back samples from din_a; results expected 4 edges later.
    task automatic run_burst(input string tag);
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5);
            data_in  = (c < 5) ? din_a[c] : 23'd0;
            tick();
            if (c == 1) chk({tag, "_sec1"}, {9'd0, dut.sec_data_s[1]}, {9'd0, s1_exp});
            if (c == 2) chk({tag, "_latency"}, {31'd0, out_valid}, 32'd0);
            if (c >= 3 && c <= 7) begin
                chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_data"}, {9'd0, out_data}, {9'd0, exp_a[c-3]});
            end
            if (c == 8) begin
                chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
                chk({tag, "_no_overrun"}, {31'd0, overrun}, 32'd0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        data_in   = 23'd0;
        flag_in   = 2'b00;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {9'd0, out_data}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_cnt", {24'd0, ovf_cnt}, 32'd0);
        chk("rst_sign", {31'd0, ovf_sign}, 32'd0);
        reset_n = 1'b1;

        // Impulse response of the third-order comb.
        din_a = '{23'd1, 23'd0, 23'd0, 23'd0, 23'd0};
        exp_a = '{23'd1, 23'h7FFFFD, 23'd3, 23'h7FFFFF, 23'd0};
        s1_exp = 23'h7FFFFF;
        run_burst("impulse");

        // Step of height 5.
        din_a = '{23'd5, 23'd5, 23'd5, 23'd5, 23'd5};
        exp_a = '{23'd5, 23'h7FFFF6, 23'd5, 23'd0, 23'd0};
        s1_exp = 23'd0;
        run_burst("step");

        // Modular wrap across the sign boundary.
        pulse_reset();
        din_a = '{23'h3FFFFF, 23'h400000, 23'd0, 23'd0, 23'd0};
        exp_a = '{23'h3FFFFF, 23'd3, 23'h7FFFFD, 23'd1, 23'h400000};
        s1_exp = 23'd1;
        run_burst("wrap");
        chk("wrap_no_flag", {24'd0, ovf_cnt}, 32'd0);

        // Backpressure: second result overwrites and sets overrun.
        pulse_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 23'd7; tick();
        in_valid = 1'b1; data_in = 23'd0; tick();
        in_valid = 1'b0; data_in = 23'd0; tick();
        tick();
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_first_data", {9'd0, out_data}, 32'd7);
        chk("bp_first_overrun", {31'd0, overrun}, 32'd0);
        tick();
        chk("bp_second_data", {9'd0, out_data}, {9'd0, 23'h7FFFEB});
        chk("bp_second_overrun", {31'd0, overrun}, 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("bp_clr_overrun", {31'd0, overrun}, 32'd0);
        chk("bp_clr_held_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_clr_held_data", {9'd0, out_data}, {9'd0, 23'h7FFFEB});
        in_valid = 1'b1; data_in = 23'd0; tick();
        in_valid = 1'b0; tick();
        tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("bp_clr_vs_set_overrun", {31'd0, overrun}, 32'd1);
        chk("bp_third_data", {9'd0, out_data}, 32'd21);
        out_ready = 1'b1; tick();
        chk("bp_accept_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_sticky_overrun", {31'd0, overrun}, 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("bp_final_clr", {31'd0, overrun}, 32'd0);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; data_in = 23'd9; tick();
        end
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        end
        din_a = '{23'd1, 23'd0, 23'd0, 23'd0, 23'd0};
        exp_a = '{23'd1, 23'h7FFFFD, 23'd3, 23'h7FFFFF, 23'd0};
        s1_exp = 23'h7FFFFF;
        run_burst("post_rst_impulse");

        // Truncation events: 300 toggles with sign bit set.
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            data_in  = 23'd0;
            flag_in  = {1'b1, ~i[0]};
            tick();
            if (i == 254) chk("ev_cnt_at_255", {24'd0, ovf_cnt}, {24'd0, EXP_CNT_SAT});
        end
        in_valid = 1'b0;
        tick();
        chk("ev_cnt_saturated", {24'd0, ovf_cnt}, {24'd0, EXP_CNT_SAT});
        chk("ev_sign", {31'd0, ovf_sign}, {31'd0, EXP_SIGN});
        in_valid = 1'b1; flag_in = 2'b11; ovf_clr = 1'b1; tick();
        ovf_clr = 1'b0;
        chk("ev_clr_with_event", {24'd0, ovf_cnt}, {24'd0, EXP_CNT_ONE});
        in_valid = 1'b1; flag_in = 2'b11; tick();
        chk("ev_no_toggle", {24'd0, ovf_cnt}, {24'd0, EXP_CNT_ONE});
        in_valid = 1'b0; flag_in = 2'b10; tick();
        chk("ev_toggle_without_strobe", {24'd0, ovf_cnt}, {24'd0, EXP_CNT_ONE});
        for (int i = 0; i < 6; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
